// File: rtl/lift_door_sequencer.sv
// Lift door / cabin-music sequencer: four-phase door FSM timed by a tick prescaler,
// with motion permit, registered music enable and a sticky motion-with-door-open fault.
module lift_door_sequencer #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned OPEN_TICKS  = 2,
  parameter int unsigned HOLD_TICKS  = 5,
  parameter int unsigned CLOSE_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       moving,
  output logic       door_open,
  output logic       music_en,
  output logic       move_ok,
  output logic [1:0] door_state,
  output logic       fault
);

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX_A = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
  localparam int unsigned TMAX   = ((TMAX_A > CLOSE_TICKS) ? TMAX_A : CLOSE_TICKS) - 1;
  localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_OPEN   = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] T_CLOSE  = TW'(CLOSE_TICKS - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TMAX);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            music_q, music_d;
  logic            fault_q, fault_d;

  logic            tick;
  logic            phase_end;
  logic            restart;
  logic [TW-1:0]   phase_last;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    phase_last = '0;
    case (state_q)
      OPENING: phase_last = T_OPEN;
      OPEN:    phase_last = T_HOLD;
      CLOSING: phase_last = T_CLOSE;
      default: phase_last = '0;
    endcase
  end

  assign phase_end = tick && (tmr_q == phase_last);

  // Priority: obstruct > open_btn > close_btn > timer expiry.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      CLOSED: begin
        if ((arrive || open_btn) && !moving) state_d = OPENING;
      end
      OPENING: begin
        if (phase_end) state_d = OPEN;
      end
      OPEN: begin
        if (obstruct || open_btn) restart = 1'b1;
        else if (close_btn)       state_d = CLOSING;
        else if (phase_end)       state_d = CLOSING;
      end
      CLOSING: begin
        if (obstruct || open_btn) state_d = OPENING;
        else if (phase_end)       state_d = CLOSED;
      end
      default: state_d = CLOSED;
    endcase
  end

  // Counters restart on every phase entry so each phase is exactly N*TICK_DIV cycles.
  always_comb begin
    pre_d = pre_q;
    tmr_d = tmr_q;
    if ((state_d != state_q) || restart || (state_q == CLOSED)) begin
      pre_d = '0;
      tmr_d = '0;
    end else if (tick) begin
      pre_d = '0;
      tmr_d = (tmr_q == T_MAX) ? tmr_q : tmr_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    music_d = moving && (state_q == CLOSED);
    fault_d = fault_q || (moving && (state_q != CLOSED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      pre_q   <= '0;
      tmr_q   <= '0;
      music_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tmr_q   <= tmr_d;
      music_q <= music_d;
      fault_q <= fault_d;
    end
  end

  assign door_state = state_q;
  assign door_open  = (state_q != CLOSED);
  assign move_ok    = (state_q == CLOSED);
  assign music_en   = music_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_lift_door_sequencer.sv
// Directed bench for lift_door_sequencer: per-scenario stimulus and expected-state
// range tables, checked every cycle one time unit after the rising edge.
module tb_lift_door_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       arrive, open_btn, close_btn, obstruct, moving;
  logic       door_open, music_en, move_ok, fault;
  logic [1:0] door_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lift_door_sequencer #(
    .TICK_DIV   (4),
    .OPEN_TICKS (2),
    .HOLD_TICKS (3),
    .CLOSE_TICKS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arrive    (arrive),
    .open_btn  (open_btn),
    .close_btn (close_btn),
    .obstruct  (obstruct),
    .moving    (moving),
    .door_open (door_open),
    .music_en  (music_en),
    .move_ok   (move_ok),
    .door_state(door_state),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   scen;
    int   lo;
    int   hi;
    logic rst;
    logic arr;
    logic opn;
    logic cls;
    logic obs;
    logic mov;
  } stim_t;

  typedef struct {
    int         scen;
    int         lo;
    int         hi;
    logic [1:0] st;
    logic       mus;
    logic       flt;
  } exp_t;

  stim_t stims[$];
  exp_t  exps[$];
  int    run_len[7] = '{42, 40, 50, 45, 42, 32, 47};

  task automatic add_stim(input int s, input int lo, input int hi,
                          input logic r, input logic a, input logic o,
                          input logic c, input logic b, input logic m);
    stim_t t;
    t.scen = s; t.lo = lo; t.hi = hi;
    t.rst = r; t.arr = a; t.opn = o; t.cls = c; t.obs = b; t.mov = m;
    stims.push_back(t);
  endtask

  task automatic add_exp(input int s, input int lo, input int hi,
                         input logic [1:0] st, input logic mus, input logic flt);
    exp_t e;
    e.scen = s; e.lo = lo; e.hi = hi; e.st = st; e.mus = mus; e.flt = flt;
    exps.push_back(e);
  endtask

  task automatic chk(input string name, input int s, input int c,
                     input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL s%0d c%0d %s: got %0d expected %0d", s, c, name, act, req);
    end
  endtask

  task automatic drive(input int s, input int c);
    rst = 1'b0; arrive = 1'b0; open_btn = 1'b0;
    close_btn = 1'b0; obstruct = 1'b0; moving = 1'b0;
    foreach (stims[i]) begin
      if (stims[i].scen == s && c >= stims[i].lo && c <= stims[i].hi) begin
        rst       = rst       | stims[i].rst;
        arrive    = arrive    | stims[i].arr;
        open_btn  = open_btn  | stims[i].opn;
        close_btn = close_btn | stims[i].cls;
        obstruct  = obstruct  | stims[i].obs;
        moving    = moving    | stims[i].mov;
      end
    end
  endtask

  task automatic check_cycle(input int s, input int c);
    foreach (exps[i]) begin
      if (exps[i].scen == s && c >= exps[i].lo && c <= exps[i].hi) begin
        chk("door_state", s, c, door_state, exps[i].st);
        chk("door_open",  s, c, {1'b0, door_open}, {1'b0, exps[i].st != 2'd0});
        chk("move_ok",    s, c, {1'b0, move_ok},   {1'b0, exps[i].st == 2'd0});
        chk("music_en",   s, c, {1'b0, music_en},  {1'b0, exps[i].mus});
        chk("fault",      s, c, {1'b0, fault},     {1'b0, exps[i].flt});
      end
    end
  endtask

  initial begin
    // s0: plain arrival cycle
    add_stim(0, 10, 10, 0, 1, 0, 0, 0, 0);
    add_exp(0, 0, 10, 2'd0, 0, 0);
    add_exp(0, 11, 18, 2'd1, 0, 0);
    add_exp(0, 19, 30, 2'd2, 0, 0);
    add_exp(0, 31, 38, 2'd3, 0, 0);
    add_exp(0, 39, 42, 2'd0, 0, 0);
    // s1: close button shortens the hold
    add_stim(1, 10, 10, 0, 1, 0, 0, 0, 0);
    add_stim(1, 22, 22, 0, 0, 0, 1, 0, 0);
    add_exp(1, 0, 10, 2'd0, 0, 0);
    add_exp(1, 11, 18, 2'd1, 0, 0);
    add_exp(1, 19, 22, 2'd2, 0, 0);
    add_exp(1, 23, 30, 2'd3, 0, 0);
    add_exp(1, 31, 40, 2'd0, 0, 0);
    // s2: obstruct during closing beats a simultaneous close button
    add_stim(2, 10, 10, 0, 1, 0, 0, 0, 0);
    add_stim(2, 34, 34, 0, 0, 0, 1, 1, 0);
    add_exp(2, 0, 10, 2'd0, 0, 0);
    add_exp(2, 11, 18, 2'd1, 0, 0);
    add_exp(2, 19, 30, 2'd2, 0, 0);
    add_exp(2, 31, 34, 2'd3, 0, 0);
    add_exp(2, 35, 42, 2'd1, 0, 0);
    add_exp(2, 43, 50, 2'd2, 0, 0);
    // s3: requests ignored while moving; held open_btn keeps door open
    add_stim(3, 0, 45, 0, 0, 1, 0, 0, 0);
    add_stim(3, 0, 19, 0, 0, 0, 0, 0, 1);
    add_exp(3, 0, 0, 2'd0, 0, 0);
    add_exp(3, 1, 20, 2'd0, 1, 0);
    add_exp(3, 21, 28, 2'd1, 0, 0);
    add_exp(3, 29, 45, 2'd2, 0, 0);
    // s4: moving while open sets sticky fault, timing unchanged
    add_stim(4, 10, 10, 0, 1, 0, 0, 0, 0);
    add_stim(4, 24, 24, 0, 0, 0, 0, 0, 1);
    add_exp(4, 0, 10, 2'd0, 0, 0);
    add_exp(4, 11, 18, 2'd1, 0, 0);
    add_exp(4, 19, 24, 2'd2, 0, 0);
    add_exp(4, 25, 30, 2'd2, 0, 1);
    add_exp(4, 31, 38, 2'd3, 0, 1);
    add_exp(4, 39, 42, 2'd0, 0, 1);
    // s5: reset mid-opening clears state, counters and fault
    add_stim(5, 10, 10, 0, 1, 0, 0, 0, 0);
    add_stim(5, 12, 12, 0, 0, 0, 0, 0, 1);
    add_stim(5, 15, 15, 1, 0, 0, 0, 0, 0);
    add_stim(5, 20, 20, 0, 1, 0, 0, 0, 0);
    add_exp(5, 0, 10, 2'd0, 0, 0);
    add_exp(5, 11, 12, 2'd1, 0, 0);
    add_exp(5, 13, 15, 2'd1, 0, 1);
    add_exp(5, 16, 20, 2'd0, 0, 0);
    add_exp(5, 21, 28, 2'd1, 0, 0);
    add_exp(5, 29, 32, 2'd2, 0, 0);
    // s6: arrive+open_btn one request; obstruct ignored in opening; open_btn restarts hold
    add_stim(6, 10, 10, 0, 1, 1, 0, 0, 0);
    add_stim(6, 14, 14, 0, 0, 0, 0, 1, 0);
    add_stim(6, 25, 25, 0, 0, 1, 1, 0, 0);
    add_exp(6, 0, 10, 2'd0, 0, 0);
    add_exp(6, 11, 18, 2'd1, 0, 0);
    add_exp(6, 19, 37, 2'd2, 0, 0);
    add_exp(6, 38, 45, 2'd3, 0, 0);
    add_exp(6, 46, 47, 2'd0, 0, 0);

    rst = 1'b1; arrive = 1'b0; open_btn = 1'b0;
    close_btn = 1'b0; obstruct = 1'b0; moving = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int s = 0; s < 7; s++) begin
      rst = 1'b1; arrive = 1'b0; open_btn = 1'b0;
      close_btn = 1'b0; obstruct = 1'b0; moving = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c <= run_len[s]; c++) begin
        drive(s, c);
        check_cycle(s, c);
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_door_sequencer.md
# lift_door_sequencer

Door and cabin-music sequencer for the lift controller. Takes arrival, door-button and obstruction inputs from the cab and drives the `door_open` and `music_en` indicators consumed by the seven-segment display. It grants `move_ok` to the motion controller only when the door is fully closed. All phase timing comes from an internal tick prescaler, so the same RTL runs at 100 MHz on the board and with small counts in simulation.

## Interface
- `TICK_DIV`, 100000000: clk cycles per timing tick (≥1; 1 = tick every cycle).
- `OPEN_TICKS`, 2: ticks spent in OPENING (≥1).
- `HOLD_TICKS`, 5: ticks door stays fully open (≥1).
- `CLOSE_TICKS`, 2: ticks spent in CLOSING (≥1).

- `clk`  in  1  system clock, 100 MHz on board.
- `rst`  in  1  reset, synchronous, active-high.
- `arrive`  in  1  one-cycle pulse: cab has stopped at a floor.
- `open_btn`  in  1  door-open button, level.
- `close_btn`  in  1  door-close button, level.
- `obstruct`  in  1  door-edge sensor, level, 1 = blocked.
- `moving`  in  1  cab in motion, from the motion controller.
- `door_open`  out  1  1 whenever the door is not fully closed (OPENING/OPEN/CLOSING).
- `music_en`  out  1  registered: cab moving with door closed.
- `move_ok`  out  1  1 = door closed, motion permitted.
- `door_state`  out  2  0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING.
- `fault`  out  1  sticky: `moving` seen while the door is not CLOSED.

## Operation
- FSM with four states. `door_state`, `door_open` and `move_ok` are Moore decodes of the state register. `move_ok` = (state == CLOSED).
- Prescaler counts 0..TICK_DIV-1. `tick` = (prescaler == TICK_DIV-1). Phase timer counts ticks.
- On every state change, prescaler and timer both clear to 0. Each phase is therefore exactly N×TICK_DIV cycles long.
- Phase end: the cycle where `tick` is high and timer == N-1. The state changes at that clock edge.
- CLOSED:
  - (`arrive` | `open_btn`) & !`moving` → OPENING.
  - Requests while `moving` = 1 are ignored and not queued.
- OPENING: phase end (OPEN_TICKS) → OPEN. Buttons and obstruct are ignored.
- OPEN:
  - Phase end (HOLD_TICKS) → CLOSING.
  - `open_btn` | `obstruct` clears timer and prescaler, restarting the hold.
  - `close_btn` & !`open_btn` & !`obstruct` → CLOSING immediately.
- CLOSING:
  - `obstruct` | `open_btn` → OPENING, with the full OPEN_TICKS phase.
  - Otherwise phase end (CLOSE_TICKS) → CLOSED.
- Priority when inputs coincide: obstruct > open_btn > close_btn > timer expiry.
- `music_en` <= `moving` & (state == CLOSED), one cycle after the inputs.
- `fault` <= `fault` | (`moving` & state != CLOSED). Cleared only by `rst`. It has no effect on FSM behaviour.

## Timing
- Reset values: state CLOSED, prescaler 0, timer 0.
- Outputs during and after reset: `door_open`=0, `music_en`=0, `move_ok`=1, `door_state`=0, `fault`=0.
- `rst` overrides all inputs in the same cycle, including mid-phase. The FSM returns to CLOSED at the next edge.
- Request sampled at edge t: state = OPENING from t+1. `move_ok` falls and `door_open` rises at t+1.
- Full cycle with no interruption, from CLOSED back to CLOSED: (OPEN_TICKS+HOLD_TICKS+CLOSE_TICKS)×TICK_DIV cycles + 1 request cycle.
- `close_btn` in OPEN at edge t: CLOSING from t+1.
- Counter widths: prescaler is clog2(TICK_DIV), minimum 1 bit. Timer holds max(OPEN,HOLD,CLOSE)_TICKS-1. Neither counter may wrap past its terminal value.
- `arrive` coinciding with `open_btn` counts as one request.
- Holding `open_btn` high keeps the door in OPEN indefinitely.

## Test plan
Parameters for all scenarios: TICK_DIV=4, OPEN_TICKS=2, HOLD_TICKS=3, CLOSE_TICKS=2, giving phases of 8/12/8 cycles.

- Reset, then `arrive` pulse at cycle 10 → OPENING 11–18, OPEN 19–30, CLOSING 31–38, CLOSED at 39. `door_open`=1 on cycles 11–38 only. `move_ok` is its inverse.
- `arrive` at 10, `close_btn` held one cycle at cycle 22 → CLOSING 23–30, CLOSED at 31.
- `arrive` at 10, `obstruct` pulse at cycle 34 (in CLOSING) → OPENING 35–42, OPEN from 43. `close_btn` at cycle 34 alongside `obstruct` changes nothing.
- `open_btn` held high from 0 while `moving`=1 → state stays CLOSED. `music_en`=1 from cycle 1. After `moving` drops at 20, door OPENING at 21 and `music_en`=0 at 21.
- `moving`=1 during OPEN → `fault`=1 the next cycle and stays 1 until `rst`. FSM timing is unchanged.
- `rst` pulsed at cycle 15 mid-OPENING → at 16: `door_state`=0, `door_open`=0, `move_ok`=1, `fault`=0. A new `arrive` at 20 gives OPENING 21–28, proving both counters cleared.
